// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
// The optional parity bit is controlled by the UART_TX_PARITY_EN macro in the
// transmitter; the state encoding below always reserves a slot for it.
package uart_pkg;

  localparam int DEFAULT_CLOCKS_PER_BIT = 4;
  localparam int DEFAULT_DATA_BITS      = 8;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START_BIT  = 3'd1,
    S_DATA_BITS  = 3'd2,
    S_STOP_BIT   = 3'd3,
    S_PARITY_BIT = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts CLOCKS_PER_BIT system clocks per serial bit and
// pulses bit_tick on the last clock of each period. Holding clear keeps the
// count at zero so the first period after release is a full one.
module uart_bit_timer #(
  parameter int CLOCKS_PER_BIT = 4
) (
  input  logic CLK,
  input  logic reset_n,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLOCKS_PER_BIT - 1);

  logic [CW-1:0] clk_cnt;

  // The tick is suppressed while cleared so an idle owner never sees one.
  assign bit_tick = !clear && (clk_cnt == LAST_COUNT);

  // Count through one bit period and wrap to zero on the tick.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      clk_cnt <= '0;
    end else if (clear || bit_tick) begin
      clk_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: serialises one word per accepted request, LSB first,
// framed as start bit, DATA_BITS data bits, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit before the stop bit;
// the receiver must be built with the same setting.
// tx_serial is registered from the next-state decode, so the line falls on
// the accepting edge and the stop bit ends exactly when done rises.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT,
  parameter int DATA_BITS      = DEFAULT_DATA_BITS
) (
  input  logic                 CLK,
  input  logic                 reset_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 done
);

  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  uart_state_e          state;
  uart_state_e          state_next;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_next;
  logic [BCW-1:0]       bit_cnt;
  logic [BCW-1:0]       bit_cnt_next;
  logic                 serial_next;
  logic                 done_next;
  logic                 accept;
  logic                 bit_tick;
  logic                 timer_clear;
`ifdef UART_TX_PARITY_EN
  logic                 parity;
  logic                 parity_next;
`endif

  assign tx_ready    = (state == S_IDLE);
  assign accept      = tx_valid && tx_ready;
  assign timer_clear = (state == S_IDLE);

  uart_bit_timer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_bit_timer (
    .CLK     (CLK),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .bit_tick(bit_tick)
  );

  // State, datapath and output registers.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      tx_serial <= 1'b1;
      done      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      shreg     <= shreg_next;
      bit_cnt   <= bit_cnt_next;
      tx_serial <= serial_next;
      done      <= done_next;
`ifdef UART_TX_PARITY_EN
      parity    <= parity_next;
`endif
    end
  end

  // Next-state, datapath update and next line level.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    done_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity;
`endif

    case (state)
      S_IDLE: begin
        if (accept) begin
          shreg_next   = tx_data;
          bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
          parity_next  = ^tx_data;
`endif
          state_next   = S_START_BIT;
        end
      end
      S_START_BIT: begin
        if (bit_tick) begin
          state_next = S_DATA_BITS;
        end
      end
      S_DATA_BITS: begin
        if (bit_tick) begin
          shreg_next   = shreg >> 1;
          bit_cnt_next = bit_cnt + BCW'(1);
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY_BIT;
`else
            state_next = S_STOP_BIT;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY_BIT: begin
        if (bit_tick) begin
          state_next = S_STOP_BIT;
        end
      end
`endif
      S_STOP_BIT: begin
        if (bit_tick) begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    serial_next = 1'b1;
    case (state_next)
      S_START_BIT:  serial_next = 1'b0;
      S_DATA_BITS:  serial_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY_BIT: serial_next = parity_next;
`endif
      default:      serial_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter (CLOCKS_PER_BIT=4, DATA_BITS=8).
// Honours UART_TX_PARITY_EN so it can be built alongside either RTL variant.
module tb_uart_transmitter;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_LEN = NBITS * CPB;

  logic       CLK;
  logic       reset_n;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_serial;
  logic       done;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  logic cmp_en = 1'b0;

  // Model: frame as a list of line levels, indexed by cycles since accept.
  logic model_frame [0:10];
  int   model_pos = -1;
  logic model_done = 1'b0;

  uart_transmitter #(
    .CLOCKS_PER_BIT(CPB),
    .DATA_BITS     (8)
  ) dut (
    .CLK      (CLK),
    .reset_n  (reset_n),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx_serial(tx_serial),
    .done     (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: accept when idle and tx_valid, then walk the frame.
  always @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      model_pos  = -1;
      model_done = 1'b0;
    end else begin
      model_done = 1'b0;
      if (model_pos < 0) begin
        if (tx_valid) begin
          model_frame[0] = 1'b0;
          for (int i = 0; i < 8; i++) model_frame[1+i] = tx_data[i];
`ifdef UART_TX_PARITY_EN
          model_frame[9]  = ^tx_data;
          model_frame[10] = 1'b1;
`else
          model_frame[9]  = 1'b1;
          model_frame[10] = 1'b1;
`endif
          model_pos = 0;
        end
      end else begin
        model_pos++;
        if (model_pos >= FRAME_LEN) begin
          model_pos  = -1;
          model_done = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (cmp_en) begin
      check_output("ready", 32'(tx_ready), 32'(model_pos < 0));
      check_output("serial", 32'(tx_serial), (model_pos < 0) ? 32'd1 : 32'(model_frame[model_pos / CPB]));
      check_output("done", 32'(done), 32'(model_done));
      if (done) done_count++;
    end
  end

  // Sends one frame, samples each bit mid-period, optionally injects a busy
  // request or an async reset at cycle index k after the accepting edge.
  task automatic apply_stimulus(input logic [7:0] d, input int inject_at, input int reset_at,
                                output logic [10:0] bits, output int done_at);
    bits    = '0;
    done_at = -1;
    @(negedge CLK);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge CLK);
    tx_valid = 1'b0;
    tx_data  = ~d;
    for (int k = 0; k < 200; k++) begin
      if ((k % CPB) == 2 && (k / CPB) < NBITS) bits[k / CPB] = tx_serial;
      if (done) begin
        done_at = k;
        break;
      end
      if (k == inject_at) begin
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
      end
      if (k == inject_at + 1) begin
        tx_valid = 1'b0;
        tx_data  = 8'hC3;
      end
      if (k == reset_at) begin
        #1 reset_n = 1'b0;
        #1;
        check_output("midreset_serial", 32'(tx_serial), 32'd1);
        check_output("midreset_done", 32'(done), 32'd0);
        check_output("midreset_ready", 32'(tx_ready), 32'd1);
        @(negedge CLK);
        @(negedge CLK);
        reset_n = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  logic [10:0] bits;
  int          done_at;
  int          d0;
  logic        seen;

  initial begin
    reset_n  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    // Test 1: reset values, then an asynchronous mid-cycle reset while idle.
    repeat (3) @(negedge CLK);
    check_output("reset_serial", 32'(tx_serial), 32'd1);
    check_output("reset_ready", 32'(tx_ready), 32'd1);
    check_output("reset_done", 32'(done), 32'd0);
    cmp_en  = 1'b1;
    reset_n = 1'b1;
    repeat (2) @(negedge CLK);
    #2 reset_n = 1'b0;
    #1;
    check_output("async_reset_serial", 32'(tx_serial), 32'd1);
    check_output("async_reset_ready", 32'(tx_ready), 32'd1);
    @(negedge CLK);
    reset_n = 1'b1;
    repeat (2) @(negedge CLK);

    // Test 2: single frame 0xA5.
    d0 = done_count;
    apply_stimulus(8'hA5, -1, -1, bits, done_at);
`ifdef UART_TX_PARITY_EN
    check_output("a5_bits", 32'(bits), 32'(11'b10101001010));
`else
    check_output("a5_bits", 32'(bits), 32'(11'b01101001010));
`endif
    check_output("a5_done_latency", 32'(done_at), 32'(FRAME_LEN));
    repeat (5) @(negedge CLK);
    check_output("a5_done_pulses", 32'(done_count - d0), 32'd1);

    // Test 3: back-to-back with tx_valid held, 0x00 then 0xFF.
    d0 = done_count;
    @(negedge CLK);
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    @(negedge CLK);
    tx_data = 8'hFF;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
    end
    check_output("b2b_first_done", 32'(seen), 32'd1);
    @(negedge CLK);
    tx_valid = 1'b0;
    check_output("b2b_gap_start", 32'(tx_serial), 32'd0);
    check_output("b2b_gap_ready", 32'(tx_ready), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
    end
    check_output("b2b_second_done", 32'(seen), 32'd1);
    repeat (10) @(negedge CLK);
    check_output("b2b_done_pulses", 32'(done_count - d0), 32'd2);

    // Test 4: busy request with 0x3C mid-frame of 0x81 is ignored.
    d0 = done_count;
    apply_stimulus(8'h81, 10, -1, bits, done_at);
`ifdef UART_TX_PARITY_EN
    check_output("busy_bits", 32'(bits), 32'(11'b10100000010));
`else
    check_output("busy_bits", 32'(bits), 32'(11'b01100000010));
`endif
    check_output("busy_done_latency", 32'(done_at), 32'(FRAME_LEN));
    repeat (FRAME_LEN + 5) @(negedge CLK);
    check_output("busy_done_pulses", 32'(done_count - d0), 32'd1);
    check_output("busy_idle_after", 32'(tx_ready), 32'd1);

    // Test 5: reset during bit 4 of 0x55, then resend 0x55.
    d0 = done_count;
    apply_stimulus(8'h55, -1, 17, bits, done_at);
    repeat (FRAME_LEN) @(negedge CLK);
    check_output("midreset_no_done", 32'(done_count - d0), 32'd0);
    apply_stimulus(8'h55, -1, -1, bits, done_at);
`ifdef UART_TX_PARITY_EN
    check_output("resend_bits", 32'(bits), 32'(11'b10010101010));
`else
    check_output("resend_bits", 32'(bits), 32'(11'b01010101010));
`endif
    check_output("resend_done_latency", 32'(done_at), 32'(FRAME_LEN));

`ifdef UART_TX_PARITY_EN
    // Test 6: parity bit values and 44-cycle frame.
    apply_stimulus(8'h07, -1, -1, bits, done_at);
    check_output("parity07_bits", 32'(bits), 32'(11'b11000001110));
    check_output("parity07_len", 32'(done_at), 32'd44);
    apply_stimulus(8'h03, -1, -1, bits, done_at);
    check_output("parity03_bits", 32'(bits), 32'(11'b10000000110));
    check_output("parity03_len", 32'(done_at), 32'd44);
`endif

    repeat (3) @(negedge CLK);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
